odd_parity_tx_ctrl: RTL and testbench
=====================================

// Module: odd_parity_tx_ctrl
// PURPOSE
//  Sequences a serial odd-parity frame: accepts a parallel word on a valid/ready
//  handshake, emits start bit, data bits LSB-first, then the odd-parity bit.
//  Controller in front of the odd-parity datapath: parity = ~^data, so that the
//  count of ones in data+parity is odd. Output drives a single serial line.
// PARAMETERS
//  DATA_W   3  data bits per frame (>=1)
//  BIT_DIV  1  clk cycles each serial bit is held (>=1)
// PORTS
//  clk         in   1       rising-edge clock, single clock domain
//  rst_n       in   1       synchronous active-low reset
//  in_valid    in   1       in_data valid
//  in_ready    out  1       ready to accept; accept = in_valid & in_ready at edge
//  in_data     in   DATA_W  word to send
//  tx_out      out  1       serial line, idles high
//  tx_busy     out  1       frame in progress
//  par_bit     out  1       parity of last accepted word, held until next accept
//  frame_done  out  1       one-cycle pulse after last bit of frame
// BEHAVIOUR
//  - All outputs registered. Reset (rst_n=0 at edge): state IDLE, tx_out=1,
//    in_ready=1, tx_busy=0, par_bit=0, frame_done=0, shift reg/counters=0.
//  - States: IDLE -> START -> DATA -> PARITY [-> STOP] -> IDLE.
//  - IDLE: in_ready=1, tx_out=1. On accept: latch in_data, par_bit<=~^in_data,
//    in_ready<=0, tx_busy<=1, go START. Start bit visible the cycle after accept.
//  - START: tx_out=0 for BIT_DIV cycles. DATA: bit i (i=0..DATA_W-1) for
//    BIT_DIV cycles each. PARITY: tx_out=par_bit for BIT_DIV cycles.
//  - Bit counter 0..BIT_DIV-1, wraps to 0 on each bit boundary; index counter
//    $clog2(DATA_W+1) bits, no overflow for any legal DATA_W.
//  - Frame length (no stop): (DATA_W+2)*BIT_DIV cycles.
//  - Final state exit: state<=IDLE, tx_out<=1, tx_busy<=0, in_ready<=1,
//    frame_done<=1 (for exactly one cycle).
//  - Back-to-back: accept allowed in the frame_done cycle; exactly one idle-high
//    cycle between frames.
//  - in_valid/in_data while busy: ignored, no accept, no effect on frame.
//  - BIT_DIV=1: one cycle per bit, no dead cycles.
//  - rst_n low mid-frame: abort at that edge, reset values next cycle, no
//    frame_done pulse, partial frame discarded.
// CONFIGURATION
//  ODDPAR_STOP_BIT_EN defined: STOP state after PARITY, tx_out=1 for BIT_DIV
//    cycles; frame length (DATA_W+3)*BIT_DIV; frame_done after STOP.
//  Not defined: no STOP state, PARITY goes directly to IDLE.
// TESTING
//  1 rst_n=0 3 cycles -> tx_out=1, in_ready=1, tx_busy=0, frame_done=0, par_bit=0.
//  2 DATA_W=3,BIT_DIV=1, send 3'b000 -> tx_out 0,0,0,0,1 then 1; frame_done 1 cyc.
//  3 sweep all 8 words -> 3'b011 gives 0,1,1,0,1; 3'b111 gives 0,1,1,1,0;
//    par_bit == ~(d2^d1^d0) for every word; ones(data+parity) always odd.
//  4 BIT_DIV=4, in_valid held high -> each bit held exactly 4 cycles, frame 20
//    cycles, single accept per frame, in_ready=0 throughout frame.
//  5 in_valid constant, words 3'b101 then 3'b010 -> exactly one idle cycle
//    between frames, two frame_done pulses, par_bit 1 then 0.
//  6 rst_n=0 during DATA bit 1 -> next cycle tx_out=1, in_ready=1, no frame_done;
//    with ODDPAR_STOP_BIT_EN, case 2 yields 0,0,0,0,1,1 and frame 6 cycles.

Source files
------------

// File: rtl/odd_parity_tx_ctrl_if.sv
// Word-input handshake for the odd-parity serial transmitter.
// Ports: in_valid/in_data driven by the producer, in_ready returned by the transmitter.
// master = producer side, slave = transmitter side.
interface odd_parity_tx_ctrl_if #(
  parameter int DATA_W = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/odd_parity_tx_ctrl.sv
// Odd-parity serial frame sequencer: start(0), data LSB-first, parity (~^data), optional stop(1).
// Latency: start bit on tx_out the cycle after accept; each bit held BIT_DIV cycles; frame_done one cycle after last bit.
// Backpressure: in_ready low for the whole frame, input ignored while busy; ODDPAR_STOP_BIT_EN adds a stop bit.
// Ports: clk, rst_n (sync, active-low), bus (in_valid/in_ready/in_data), tx_out, tx_busy, par_bit, frame_done.
module odd_parity_tx_ctrl #(
  parameter int DATA_W  = 3,
  parameter int BIT_DIV = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  odd_parity_tx_ctrl_if.slave bus,
  output logic                tx_out,
  output logic                tx_busy,
  output logic                par_bit,
  output logic                frame_done
);

  // Keep the bit counter at least one bit wide so BIT_DIV=1 stays legal.
  localparam int BC_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam int IX_W = $clog2(DATA_W + 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BIT_DIV - 1);
  localparam logic [IX_W-1:0] IX_LAST = IX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            state, state_nxt;
  logic [BC_W-1:0]   bit_cnt, bit_cnt_nxt;
  logic [IX_W-1:0]   idx, idx_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt, sh_next;
  logic              in_ready, in_ready_nxt;
  logic              tx_nxt, busy_nxt, par_nxt, done_nxt;
  logic              bit_last, end_frame;

  assign bus.in_ready = in_ready;

  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    idx_nxt      = idx;
    shreg_nxt    = shreg;
    in_ready_nxt = in_ready;
    tx_nxt       = tx_out;
    busy_nxt     = tx_busy;
    par_nxt      = par_bit;
    done_nxt     = 1'b0;
    end_frame    = 1'b0;
    sh_next      = shreg >> 1;
    bit_last     = (bit_cnt == BC_LAST);

    // Outside IDLE the bit counter free-runs and wraps on each bit boundary.
    if (state != S_IDLE) begin
      bit_cnt_nxt = bit_last ? '0 : bit_cnt + BC_W'(1);
    end

    case (state)
      S_IDLE: begin
        bit_cnt_nxt = '0;
        if (bus.in_valid && in_ready) begin
          shreg_nxt    = bus.in_data;
          par_nxt      = ~^bus.in_data;
          in_ready_nxt = 1'b0;
          busy_nxt     = 1'b1;
          tx_nxt       = 1'b0;
          idx_nxt      = '0;
          state_nxt    = S_START;
        end
      end
      S_START: begin
        if (bit_last) begin
          state_nxt = S_DATA;
          tx_nxt    = shreg[0];
          idx_nxt   = '0;
        end
      end
      S_DATA: begin
        if (bit_last) begin
          if (idx == IX_LAST) begin
            state_nxt = S_PARITY;
            tx_nxt    = par_bit;
          end else begin
            // shreg[0] is always the bit currently on the line.
            idx_nxt   = idx + IX_W'(1);
            shreg_nxt = sh_next;
            tx_nxt    = sh_next[0];
          end
        end
      end
      S_PARITY: begin
        if (bit_last) begin
`ifdef ODDPAR_STOP_BIT_EN
          state_nxt = S_STOP;
          tx_nxt    = 1'b1;
`else
          end_frame = 1'b1;
`endif
        end
      end
`ifdef ODDPAR_STOP_BIT_EN
      S_STOP: begin
        if (bit_last) begin
          end_frame = 1'b1;
        end
      end
`endif
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    if (end_frame) begin
      state_nxt    = S_IDLE;
      tx_nxt       = 1'b1;
      busy_nxt     = 1'b0;
      in_ready_nxt = 1'b1;
      done_nxt     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      idx        <= '0;
      shreg      <= '0;
      in_ready   <= 1'b1;
      tx_out     <= 1'b1;
      tx_busy    <= 1'b0;
      par_bit    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      idx        <= idx_nxt;
      shreg      <= shreg_nxt;
      in_ready   <= in_ready_nxt;
      tx_out     <= tx_nxt;
      tx_busy    <= busy_nxt;
      par_bit    <= par_nxt;
      frame_done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_odd_parity_tx_ctrl.sv
// Bench for odd_parity_tx_ctrl: one instance with BIT_DIV=1 (dut 0) and one with BIT_DIV=4 (dut 1).
// A queue-based frame model predicts every output on every cycle; directed cases pin literal sequences.
// Honours ODDPAR_STOP_BIT_EN the same way the design does.
module tb_odd_parity_tx_ctrl;
  localparam int W = 3;
`ifdef ODDPAR_STOP_BIT_EN
  localparam int NB = W + 3;
  localparam bit STOP = 1'b1;
`else
  localparam int NB = W + 2;
  localparam bit STOP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic         vld [2];
  logic [W-1:0] dat [2];

  odd_parity_tx_ctrl_if #(.DATA_W(W)) if_a ();
  odd_parity_tx_ctrl_if #(.DATA_W(W)) if_b ();
  assign if_a.in_valid = vld[0];
  assign if_a.in_data  = dat[0];
  assign if_b.in_valid = vld[1];
  assign if_b.in_data  = dat[1];

  logic tx_a, busy_a, par_a, done_a;
  logic tx_b, busy_b, par_b, done_b;

  odd_parity_tx_ctrl #(.DATA_W(W), .BIT_DIV(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a),
    .tx_out(tx_a), .tx_busy(busy_a), .par_bit(par_a), .frame_done(done_a)
  );
  odd_parity_tx_ctrl #(.DATA_W(W), .BIT_DIV(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b),
    .tx_out(tx_b), .tx_busy(busy_b), .par_bit(par_b), .frame_done(done_b)
  );

  int checks = 0;
  int errors = 0;

  // Model: per-dut queue of line values still to be driven, one entry per cycle.
  bit   q [2][$];
  logic e_tx [2], e_rdy [2], e_busy [2], e_par [2], e_done [2], wb [2];

  function automatic int bd(int k);
    return (k == 0) ? 1 : 4;
  endfunction

  function automatic logic [4:0] got(int k);
    if (k == 0) return {tx_a, if_a.in_ready, busy_a, par_a, done_a};
    return {tx_b, if_b.in_ready, busy_b, par_b, done_b};
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (dut%0d): got %0h, expected %0h", nm, k, act, exp);
    end
  endtask

  task automatic model_reset(int k);
    q[k].delete();
    e_tx[k] = 1'b1; e_rdy[k] = 1'b1; e_busy[k] = 1'b0;
    e_par[k] = 1'b0; e_done[k] = 1'b0; wb[k] = 1'b0;
  endtask

  // One clock: capture what the DUTs see at the edge, advance the model, compare every output.
  task automatic step();
    logic         acc [2];
    logic [W-1:0] d   [2];
    logic         r;
    logic [4:0]   o;
    bit           v;
    r = rst_n;
    for (int k = 0; k < 2; k++) begin
      acc[k] = r && vld[k] && e_rdy[k];
      d[k]   = dat[k];
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (!r) begin
        model_reset(k);
      end else begin
        if (acc[k]) begin
          e_par[k] = (($countones(d[k]) % 2) == 0);
          for (int b = 0; b < NB; b++) begin
            if (b == 0)           v = 1'b0;
            else if (b <= W)      v = d[k][b-1];
            else if (b == W + 1)  v = e_par[k];
            else                  v = 1'b1;
            for (int j = 0; j < bd(k); j++) q[k].push_back(v);
          end
        end
        if (q[k].size() > 0) begin
          e_tx[k] = q[k].pop_front();
          e_busy[k] = 1'b1; e_rdy[k] = 1'b0; e_done[k] = 1'b0; wb[k] = 1'b1;
        end else begin
          e_tx[k] = 1'b1; e_busy[k] = 1'b0; e_rdy[k] = 1'b1;
          e_done[k] = wb[k]; wb[k] = 1'b0;
        end
      end
      o = got(k);
      chk("tx_out",     k, o[4], e_tx[k]);
      chk("in_ready",   k, o[3], e_rdy[k]);
      chk("tx_busy",    k, o[2], e_busy[k]);
      chk("par_bit",    k, o[1], e_par[k]);
      chk("frame_done", k, o[0], e_done[k]);
    end
  endtask

  task automatic wait_idle(int k);
    logic [4:0] o;
    for (int i = 0; i < 100; i++) begin
      o = got(k);
      if (o[3] && !o[2]) break;
      step();
    end
    o = got(k);
    chk("idle_wait", k, o[3], 1);
  endtask

  // Send one word and record the line from the start bit up to (not including) the frame_done cycle.
  task automatic send_capture(input int k, input logic [W-1:0] d, output logic [15:0] seq, output int len);
    logic [4:0] o;
    wait_idle(k);
    vld[k] = 1'b1; dat[k] = d;
    step();
    vld[k] = 1'b0;
    seq = '0; len = 0;
    o = got(k);
    while (!o[0] && len < 64) begin
      seq = {seq[14:0], o[4]};
      len++;
      step();
      o = got(k);
    end
    chk("frame_done_seen", k, o[0], 1);
  endtask

  logic [4:0]  tbl [8];
  logic [15:0] seq, exp_seq;
  int          len, pulses, idle, accs;
  logic [4:0]  o;

  initial begin
    // Hand-derived no-stop line sequences {start, d0, d1, d2, parity}, first bit in the MSB.
    tbl[0] = 5'b00001; tbl[1] = 5'b01000; tbl[2] = 5'b00100; tbl[3] = 5'b01101;
    tbl[4] = 5'b00010; tbl[5] = 5'b01011; tbl[6] = 5'b00111; tbl[7] = 5'b01110;
    for (int k = 0; k < 2; k++) begin
      vld[k] = 1'b0; dat[k] = '0; model_reset(k);
    end

    // Reset held for three cycles.
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    chk("rst_tx_out", 0, tx_a, 1);
    chk("rst_in_ready", 0, if_a.in_ready, 1);
    chk("rst_tx_busy", 0, busy_a, 0);
    chk("rst_frame_done", 0, done_a, 0);
    chk("rst_par_bit", 0, par_a, 0);
    step();

    // All eight words on the single-cycle-per-bit instance.
    for (int w = 0; w < 8; w++) begin
      send_capture(0, w[W-1:0], seq, len);
      exp_seq = STOP ? {10'd0, tbl[w], 1'b1} : {11'd0, tbl[w]};
      chk("frame_len_div1", 0, len, NB);
      chk("line_seq", 0, seq, exp_seq);
      chk("ones_odd", 0, $countones({w[W-1:0], par_a}) % 2, 1);
    end

    // BIT_DIV=4 with in_valid held high: two full frames, one accept each.
    wait_idle(1);
    send_capture(1, 3'b101, seq, len);
    chk("frame_len_div4", 1, len, NB * 4);
    wait_idle(1);
    vld[1] = 1'b1;
    pulses = 0; accs = 0;
    for (int c = 0; c < 2 * NB * 4 + 2; c++) begin
      dat[1] = 3'($urandom_range(0, 7));
      o = got(1);
      if (o[3]) accs++;
      step();
      o = got(1);
      if (o[0]) pulses++;
    end
    vld[1] = 1'b0;
    chk("div4_accepts", 1, accs, 2);
    chk("div4_done_pulses", 1, pulses, 2);

    // Back-to-back 101 then 010 with in_valid constant; data changes mid-frame are ignored.
    wait_idle(0);
    vld[0] = 1'b1; dat[0] = 3'b101;
    step();
    chk("b2b_par_first", 0, par_a, 1);
    dat[0] = 3'b010;
    pulses = 0; idle = 0;
    for (int c = 2; c <= 2 * NB + 2; c++) begin
      step();
      if (done_a) pulses++;
      if (!busy_a && c < 2 * NB + 2) idle++;
      if (c == NB + 2) chk("b2b_par_second", 0, par_a, 0);
      if (c == 2 * NB + 1) vld[0] = 1'b0;
    end
    chk("b2b_done_pulses", 0, pulses, 2);
    chk("b2b_idle_cycles", 0, idle, 1);

    // Reset during data bit 1 aborts the frame with no frame_done.
    wait_idle(0);
    vld[0] = 1'b1; dat[0] = 3'b110;
    step();
    vld[0] = 1'b0;
    step();
    step();
    chk("abort_in_data", 0, busy_a, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("abort_tx_out", 0, tx_a, 1);
    chk("abort_in_ready", 0, if_a.in_ready, 1);
    chk("abort_done", 0, done_a, 0);
    step();
    chk("abort_no_late_done", 0, done_a, 0);

    // Random traffic on both instances with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 2; k++) begin
        vld[k] = ($urandom_range(0, 99) < 60);
        dat[k] = 3'($urandom_range(0, 7));
      end
      rst_n = ($urandom_range(0, 299) != 0);
      step();
    end
    rst_n = 1'b1;
    vld[0] = 1'b0; vld[1] = 1'b0;
    repeat (40) step();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
